// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operator and error encodings,
// FSM state type and default datapath widths.
package calc_pkg;

  localparam int unsigned CALC_W  = 9;
  localparam int unsigned CALC_RW = 2 * CALC_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_SYNTAX  = 3'b001;
  localparam logic [2:0] ERR_ALU     = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_OVF     = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_A,
    ST_GOT_OP,
    ST_EXEC,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/calc_watchdog.sv
// Saturating cycle counter guarding an ALU launch; expired is high once the
// count has reached TIMEOUT.
module calc_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: collects A op B tokens, launches the shared ALU under a
// watchdog and reports result / error code, with result chaining into operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned W       = CALC_W,
  parameter int unsigned RW      = 2 * W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [W-1:0]  tok_number,
  input  logic [1:0]    tok_op,
  output logic          alu_start,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  input  logic          alu_done,
  input  logic [RW-1:0] alu_result,
  input  logic          alu_error,
  output logic          result_valid,
  output logic [RW-1:0] result,
  output logic [2:0]    err_code,
  output logic          busy
);

  state_t     state, state_n;
  logic       accept;
  logic       ld_a_num, ld_a_res, ld_op, ld_b, launch, set_res, pulse;
  logic [2:0] err_n;
  logic       wd_clr, wd_en, wd_expired;

  assign tok_ready = (state != ST_EXEC);
  assign busy      = (state == ST_EXEC);
  assign accept    = tok_valid & tok_ready;

  // The launch cycle already counts as 1 so expiry lands TIMEOUT cycles after alu_start.
  assign wd_en  = launch | (state == ST_EXEC);
  assign wd_clr = ~wd_en;

  calc_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ld_a_num = 1'b0;
    ld_a_res = 1'b0;
    ld_op    = 1'b0;
    ld_b     = 1'b0;
    launch   = 1'b0;
    set_res  = 1'b0;
    pulse    = 1'b0;
    err_n    = err_code;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (tok_is_op) begin
            err_n   = ERR_SYNTAX;
            pulse   = 1'b1;
            state_n = ST_ERR;
          end else begin
            ld_a_num = 1'b1;
            state_n  = ST_GOT_A;
          end
        end
      end
      ST_GOT_A: begin
        if (accept) begin
          if (tok_is_op) begin
            ld_op   = 1'b1;
            state_n = ST_GOT_OP;
          end else begin
            ld_a_num = 1'b1;
          end
        end
      end
      ST_GOT_OP: begin
        if (accept) begin
          if (tok_is_op) begin
            ld_op = 1'b1;
          end else begin
            ld_b    = 1'b1;
            launch  = 1'b1;
            state_n = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // alu_done is checked first so a completion on the expiry cycle still wins.
        if (alu_done) begin
          pulse = 1'b1;
          if (alu_error) begin
            err_n   = ERR_ALU;
            state_n = ST_ERR;
          end else begin
            set_res = 1'b1;
            err_n   = ERR_NONE;
            state_n = ST_DONE;
          end
        end else if (wd_expired) begin
          err_n   = ERR_TIMEOUT;
          pulse   = 1'b1;
          state_n = ST_ERR;
        end
      end
      ST_DONE: begin
        if (accept) begin
          if (!tok_is_op) begin
            ld_a_num = 1'b1;
            state_n  = ST_GOT_A;
          end else if (result[RW-1:W] == '0) begin
            ld_a_res = 1'b1;
            ld_op    = 1'b1;
            state_n  = ST_GOT_OP;
          end else begin
            err_n   = ERR_OVF;
            pulse   = 1'b1;
            state_n = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (accept && !tok_is_op) begin
          ld_a_num = 1'b1;
          err_n    = ERR_NONE;
          state_n  = ST_GOT_A;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_start    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result       <= '0;
      err_code     <= ERR_NONE;
      result_valid <= 1'b0;
    end else begin
      alu_start    <= launch;
      result_valid <= pulse;
      err_code     <= err_n;
      if (ld_a_num) begin
        alu_a <= tok_number;
      end else if (ld_a_res) begin
        alu_a <= result[W-1:0];
      end
      if (ld_op) begin
        alu_op <= tok_op;
      end
      if (ld_b) begin
        alu_b <= tok_number;
      end
      if (set_res) begin
        result <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected launches/results are queued as
// tokens are driven and checked when alu_start / result_valid appear.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned W  = 9;
  localparam int unsigned RW = 18;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic [W-1:0]  tok_number = '0;
  logic [1:0]    tok_op = '0;
  logic          alu_start;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_op;
  logic          alu_done = 1'b0;
  logic [RW-1:0] alu_result = '0;
  logic          alu_error = 1'b0;
  logic          result_valid;
  logic [RW-1:0] result;
  logic [2:0]    err_code;
  logic          busy;

  always #5 clk = ~clk;

  calc_sequencer #(.W(W), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_number(tok_number), .tok_op(tok_op),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
    .result_valid(result_valid), .result(result), .err_code(err_code), .busy(busy)
  );

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op; } launch_t;
  typedef struct { logic [RW-1:0] res; logic [2:0] err; } res_t;

  launch_t launch_q[$];
  res_t    res_q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void exp_launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    launch_t l;
    l.a = a; l.b = b; l.op = op;
    launch_q.push_back(l);
  endfunction

  function automatic void exp_res(input logic [RW-1:0] res, input logic [2:0] err);
    res_t r;
    r.res = res; r.err = err;
    res_q.push_back(r);
  endfunction

  // Monitor
  logic    prev_start = 1'b0;
  launch_t mon_l;
  res_t    mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_start) begin
        check("start_single", prev_start, 0);
        if (launch_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          mon_l = launch_q.pop_front();
          check("alu_a", alu_a, mon_l.a);
          check("alu_b", alu_b, mon_l.b);
          check("alu_op", alu_op, mon_l.op);
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          check("unexpected_result_valid", 1, 0);
        end else begin
          mon_r = res_q.pop_front();
          check("result", result, mon_r.res);
          check("err_code", err_code, mon_r.err);
        end
      end
    end
    prev_start = alu_start;
  end

  task automatic send(input logic is_op, input logic [W-1:0] num, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    tok_valid = 1'b1; tok_is_op = is_op; tok_number = num; tok_op = op;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    tok_valid = 1'b0; tok_is_op = 1'b0; tok_number = '0; tok_op = '0;
    if (!ok) check("tok_accept", 0, 1);
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (alu_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_seen", 0, 1);
  endtask

  task automatic alu_reply(input int unsigned dly, input logic [RW-1:0] val, input logic err);
    repeat (dly) @(posedge clk);
    #1;
    alu_done = 1'b1; alu_result = val; alu_error = err;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_error = 1'b0;
  endtask

  task automatic expr(input logic [W-1:0] a, input logic [1:0] op, input logic [W-1:0] b);
    send(1'b0, a, 2'b00);
    send(1'b1, '0, op);
    send(1'b0, b, 2'b00);
    wait_start();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int nr;

    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_err", err_code, ERR_NONE);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start", alu_start, 0);
    check("rst_ready", tok_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Operator as first token
    exp_res(0, ERR_SYNTAX);
    send(1'b1, '0, OP_ADD);

    // Basic add (also clears the syntax error)
    exp_launch(12, 30, OP_ADD);
    exp_res(42, ERR_NONE);
    expr(12, OP_ADD, 30);
    alu_reply(2, 42, 1'b0);

    // Chain: 42 * 3
    exp_launch(42, 3, OP_MUL);
    exp_res(126, ERR_NONE);
    send(1'b1, '0, OP_MUL);
    send(1'b0, 3, 2'b00);
    wait_start();
    alu_reply(2, 126, 1'b0);
    check("result_hold", result, 126);

    // Chain overflow
    exp_launch(20, 30, OP_MUL);
    exp_res(600, ERR_NONE);
    expr(20, OP_MUL, 30);
    alu_reply(3, 600, 1'b0);
    exp_res(600, ERR_OVF);
    send(1'b1, '0, OP_SUB);
    send(1'b0, 7, 2'b00);
    @(negedge clk);
    check("ovf_cleared", err_code, ERR_NONE);
    exp_launch(7, 1, OP_ADD);
    exp_res(8, ERR_NONE);
    send(1'b1, '0, OP_ADD);
    send(1'b0, 1, 2'b00);
    wait_start();
    alu_reply(1, 8, 1'b0);

    // ALU fault keeps the previous result
    exp_launch(5, 0, OP_DIV);
    exp_res(8, ERR_ALU);
    expr(5, OP_DIV, 0);
    alu_reply(2, 18'h3FFFF, 1'b1);

    // Timeout with a token offered during EXEC
    exp_launch(4, 4, OP_ADD);
    exp_res(8, ERR_TIMEOUT);
    expr(4, OP_ADD, 4);
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_number = 99;
    k = 0;
    nr = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (err_code == ERR_TIMEOUT) begin
        k = n;
        break;
      end
      if (tok_ready) nr++;
    end
    tok_valid = 1'b0; tok_number = '0;
    check("timeout_cycle", k, TO);
    check("ready_low_in_exec", nr, 0);
    @(posedge clk); #1;

    // Operator ignored in ERR; the 99 must not have been consumed
    send(1'b1, '0, OP_MUL);
    exp_launch(9, 1, OP_ADD);
    exp_res(10, ERR_NONE);
    expr(9, OP_ADD, 1);
    alu_reply(2, 10, 1'b0);

    // Reset one cycle after alu_start, then a stray alu_done
    exp_launch(2, 3, OP_ADD);
    expr(2, OP_ADD, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", alu_a, 0);
    check("mid_rst_b", alu_b, 0);
    check("mid_rst_op", alu_op, 0);
    check("mid_rst_start", alu_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_err", err_code, ERR_NONE);
    check("mid_rst_rv", result_valid, 0);
    check("mid_rst_ready", tok_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    alu_done = 1'b1; alu_result = 77;
    @(posedge clk); #1;
    alu_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_result", result, 0);
    check("res_q_drained", res_q.size(), 0);
    check("launch_q_drained", launch_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central controller of the calculator datapath. Accepts parsed tokens (operands and operators) from the interpreter stage and sequences them as A op B. Launches the shared ALU with a start/done handshake, guards it with a timeout watchdog, and presents the result or an error code to the display/transmit stage. Supports chained expressions: the previous result becomes operand A.

Parameters:
W, 9, operand width in bits (matches interpreter number width)
RW, 18, ALU result width (2*W)
TIMEOUT, 64, max cycles from alu_start to alu_done before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token offered this cycle
tok_ready  out  1  sequencer can accept a token; transfer when tok_valid & tok_ready
tok_is_op  in  1  1 = operator token, 0 = number token
tok_number  in  W  operand value (number tokens)
tok_op  in  2  operator: 00 add, 01 sub, 10 mul, 11 div
alu_start  out  1  one-cycle launch pulse
alu_a  out  W  operand A, stable from alu_start until done/abort
alu_b  out  W  operand B, same stability rule
alu_op  out  2  operator, same stability rule
alu_done  in  1  ALU result valid, one-cycle pulse
alu_result  in  RW  ALU result, sampled when alu_done=1
alu_error  in  1  ALU fault (e.g. divide by zero), qualified by alu_done
result_valid  out  1  one-cycle pulse when result/err_code updates
result  out  RW  last good result, held
err_code  out  3  000 none, 001 syntax, 010 alu fault, 011 timeout, 100 chain overflow; held
busy  out  1  high in EXEC

Behaviour:
- Reset (async, rst_n=0): state IDLE; alu_start=0, alu_a/alu_b/alu_op=0, result=0, err_code=000, result_valid=0, busy=0, watchdog cleared. Reset during EXEC aborts silently. A later alu_done is ignored.
- tok_ready=1 in every state except EXEC.
- States and transitions (only on accepted tokens, except EXEC):
  IDLE: number -> A=tok_number, GOT_A. Operator -> err_code=001, result_valid pulse, ERR.
  GOT_A: operator -> latch op, GOT_OP. Number -> overwrite A, stay.
  GOT_OP: number -> B=tok_number, alu_start=1 next cycle, EXEC. Operator -> overwrite op, stay.
  EXEC: watchdog counts from 1 on the cycle alu_start is high.
    - alu_done & !alu_error -> result=alu_result, err_code=000, DONE.
    - alu_done & alu_error -> err_code=010, result unchanged, ERR.
    - Count reaches TIMEOUT without done -> err_code=011, ERR.
    - alu_done on the same cycle as timeout: done wins.
  DONE: number -> A=tok_number, GOT_A (new expression). Operator -> if result <= 2^W-1 then A=result[W-1:0], op latched, GOT_OP. Otherwise err_code=100, ERR.
  ERR: number -> A=tok_number, err_code cleared to 000 (no pulse), GOT_A. Operator ignored, stay.
- result_valid: single-cycle pulse on the cycle after entering DONE or ERR (including ERR from IDLE/DONE). Registered, so latency is 1 cycle from alu_done.
- alu_start high exactly 1 cycle per launch. alu_a/b/op are registered and unchanged while busy=1.
- No arithmetic in this block beyond the chain-overflow compare (result[RW-1:W] != 0) and the watchdog increment. The watchdog saturates and never wraps.

Decomposition:
- Shared package calc_pkg: op encodings (OP_ADD..OP_DIV), err_code constants (ERR_NONE..ERR_OVF), state encoding localparams, default W/RW.
- Sub-module calc_watchdog: counter with clear/enable inputs and an expired output at TIMEOUT, parameterised by TIMEOUT, same clk/rst_n.
- The rest is one FSM plus operand/result registers in calc_sequencer.

Test Plan:
- Basic add: tokens 12, add(00), 30 -> one alu_start pulse with a=12, b=30, op=00. ALU returns done with 42 two cycles later -> result=42, err_code=000, result_valid pulse 1 cycle later.
- Chaining: after result 42, tokens mul(10), 3 -> alu_a=42, alu_b=3, op=10. Result 126 -> result=126.
- Chain overflow: result 600 (>511), then token sub -> err_code=100, one result_valid pulse. Next token 7 -> err_code=000, state GOT_A.
- ALU fault: 5, div(11), 0, alu_done with alu_error=1 -> err_code=010, result keeps previous value.
- Timeout: TIMEOUT=16, no alu_done -> err_code=011 on cycle 16 after alu_start. tok_ready=0 throughout EXEC. A token offered during EXEC is not consumed.
- Reset mid-EXEC: rst_n low 1 cycle after alu_start -> all outputs 0 immediately, IDLE. A stray alu_done afterwards -> no result_valid. Also: operator as first token -> err_code=001.
